// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding and sizing helpers for the serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-digit build still needs a one-bit counter to stay a legal vector.
    function automatic int cnt_width(input int width, input int digit);
        return (width / digit > 1) ? $clog2(width / digit) : 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// digit_adder: combinational ripple of DIGIT full-adder cells.
// Also exposes the carry into the top cell so the caller can derive signed overflow.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             cm
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[DIGIT];
    assign cm = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial add/subtract, DIGIT bits per clock through a registered carry,
// with start/done handshake, carry-out and two's-complement overflow.
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cIn,
    output logic [WIDTH-1:0] z,
    output logic             cOut,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(WIDTH, DIGIT);

    if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
        $error("serial_addsub: WIDTH must be >= 2 and DIGIT must divide WIDTH");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, z_q, z_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [DIGIT-1:0] sum;
    logic             co, cm;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a  (a_q[DIGIT-1:0]),
        .b  (b_q[DIGIT-1:0]),
        .ci (carry_q),
        .s  (sum),
        .co (co),
        .cm (cm)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        z_d     = z_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q != RUN && start) begin
            a_d     = x;
            b_d     = sub ? ~y : y;
            carry_d = sub | cIn;
            cnt_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            // Sum digits enter at the top so after N shifts the LSB digit lands at bit 0.
            acc_d   = (acc_q >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = co;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
                z_d     = acc_d;
                cout_d  = co;
                ovf_d   = cm ^ co;
                state_d = DONE;
            end
        end else begin
            state_d = IDLE;
        end
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            z_q     <= z_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign z    = z_q;
    assign cOut = cout_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Multi-cycle, parametrised adder/subtractor that processes its operands DIGIT bits per clock with a registered carry. It is the sequential, width-generic successor to the single-bit full-adder cell. It sits on the datapath wherever area matters more than latency, and is driven by a start/done handshake from a controller. Add and subtract modes share one carry chain, and the block reports carry-out and signed overflow.

## Interface
- WIDTH, 8: operand/result width in bits; ≥ 2.
- DIGIT, 1: bits processed per cycle; must divide WIDTH (elaboration error otherwise).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when not busy.
- sub  in  1  0 = add, 1 = subtract; sampled with start.
- x  in  WIDTH  operand A; sampled with start.
- y  in  WIDTH  operand B; sampled with start.
- cIn  in  1  carry-in for add; ignored when sub=1.
- z  out  WIDTH  result register.
- cOut  out  1  carry out of MSB (for subtract, 1 = no borrow).
- ovf  out  1  two's-complement overflow.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.

## Operation
- The block has three states: IDLE, RUN, DONE. All outputs reset to 0. Reset forces IDLE and clears the operand, carry and counter registers.
- Reset is asynchronous: rst_n low at any time, including mid-RUN, aborts the operation immediately. No done pulse is produced and z/cOut/ovf read 0.
- IDLE or DONE with start=1 at an edge:
  - Latch a=x.
  - Latch b = sub ? ~y : y.
  - Set carry = sub ? 1 : cIn.
  - Set digit counter = 0 and go to RUN.
- RUN, each edge:
  - Add the DIGIT LSBs of a and b plus carry through a DIGIT-bit ripple of full-adder cells.
  - Shift the sum digit into the top of the accumulator.
  - Shift a and b right by DIGIT.
  - Register the new carry and increment the counter.
- The last digit is processed when counter = WIDTH/DIGIT−1. That edge also:
  - loads z from the accumulator;
  - sets cOut to the final carry;
  - sets ovf = carry into MSB XOR carry out of MSB;
  - moves the state to DONE.
- DONE lasts one cycle with done=1. With no start, the next edge returns to IDLE. With start=1, the operation is accepted back-to-back.
- start while in RUN is ignored. x, y, sub and cIn may change freely after the accept edge.
- z, cOut and ovf hold their last result through IDLE and through a following RUN until the next completion.
- All arithmetic is modulo 2^WIDTH, with no saturation.

## Timing
- Accept edge E0 (start sampled high in IDLE/DONE): busy rises after E0.
- Digit edges are E1…EN, where N = WIDTH/DIGIT. Results update at EN.
- done=1 and busy=0 in the cycle after EN. Latency is N edges from accept to done.
- Throughput: one operation per N+1 cycles when start is held high.
- There are no combinational paths from inputs to outputs. All outputs are registered.

## Structure
- Shared package `serial_arith_pkg`:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - helper constant function for the counter width, $clog2(WIDTH/DIGIT).
- One sub-module, `digit_adder #(DIGIT)`: a purely combinational ripple of DIGIT full-adder cells. It takes a[DIGIT], b[DIGIT] and ci, and returns s[DIGIT], co and the carry into its top bit (needed for ovf).

## Test plan
- **Reset:** assert rst_n=0 with random inputs → z=0, cOut=0, ovf=0, busy=0, done=0. Release rst_n, hold start=0 for 5 cycles → state stays idle, all outputs 0.
- **Add (WIDTH=8, DIGIT=1):** x=0x5A, y=0x3C, cIn=1, sub=0 → z=0x97, cOut=0, ovf=1. done is high exactly in the cycle after the 8th edge following the accept edge, and busy is high for 8 cycles.
- **Subtract:** x=0x10, y=0x20, sub=1, cIn=1 (ignored) → z=0xF0, cOut=0, ovf=0.
- **Overflow/carry corners:**
  - x=0xFF, y=0x01, cIn=0 → z=0x00, cOut=1, ovf=0.
  - x=0x80, y=0xFF, add → z=0x7F, cOut=1, ovf=1.
- **Handshake:**
  - Pulse start again mid-RUN → ignored, and the result matches the first operands.
  - Hold start high continuously → operations complete every 9 cycles with one done pulse each.
- **Reset mid-RUN and DIGIT=4 build:**
  - rst_n low at the 3rd digit edge → no done pulse, outputs 0.
  - With WIDTH=8, DIGIT=4, run exhaustive x, y, cIn, sub against a reference model → done 2 edges after accept, and z/cOut/ovf always match.
